// File: rtl/phase_a_pkg.sv
// Shared definitions for the phase_a modular-doubling block: default widths,
// the job-controller state encoding and the iteration counter type.
package phase_a_pkg;

    localparam int unsigned DEFAULT_W     = 3072;
    localparam int unsigned DEFAULT_SHIFT = 64;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned M_PRIME_W     = 110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mod_double.sv
// Combinational modular doubling: returns (2*r) mod m, where m is supplied
// only as its negative m_n = 2^(W+2) - m. Requires r < m.
module mod_double #(
    parameter int unsigned W = 3072
) (
    input  logic [W-1:0] r_i,
    input  logic [W+1:0] m_n_i,
    output logic [W-1:0] dbl_o
);

    logic [W-1:0] d_low_s;
    logic [W-1:0] s_low_s;
    logic [1:0]   s_mid_unused_s;
    logic         s_top_s;

    // d = 2r; s = d + 2^(W+2) - m carries into bit W+2 exactly when d >= m.
    always_comb begin
        d_low_s = {r_i[W-2:0], 1'b0};
        {s_top_s, s_mid_unused_s, s_low_s} = {2'b00, r_i, 1'b0} + {1'b0, m_n_i};
        if (s_top_s) begin
            dbl_o = s_low_s;
        end else begin
            dbl_o = d_low_s;
        end
    end

endmodule

// File: rtl/phase_a_core.sv
// Phase A job controller: latches an operand and computes
// (a * 2^SHIFT) mod m by SHIFT successive modular doublings.
module phase_a_core
    import phase_a_pkg::*;
#(
    parameter int unsigned SHIFT = DEFAULT_SHIFT,
    parameter int unsigned W     = DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         m,
    input  logic [W+1:0]         m_n,
    input  logic [M_PRIME_W-1:0] m_prime,
    input  logic                 en,
    output logic [W-1:0]         new_a,
    output logic                 en_out
);

    localparam cnt_t LAST_ITER = cnt_t'(SHIFT - 1);

    state_e       state_q, state_d;
    cnt_t         cnt_q,   cnt_d;
    logic [W-1:0] r_q,     r_d;
    logic [W+1:0] mn_q,    mn_d;
    logic [W-1:0] new_a_q, new_a_d;
    logic         en_out_q, en_out_d;
    logic [W-1:0] dbl_s;

    // m is implied by m_n, and m_prime belongs to later phases.
    logic unused_inputs_s;
    assign unused_inputs_s = ^{m, m_prime};

    mod_double #(
        .W(W)
    ) u_mod_double (
        .r_i   (r_q),
        .m_n_i (mn_q),
        .dbl_o (dbl_s)
    );

    // Next-state logic for the IDLE -> RUN -> DONE job sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        mn_d     = mn_q;
        new_a_d  = new_a_q;
        en_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    r_d     = a;
                    mn_d    = m_n;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                r_d = dbl_s;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                new_a_d  = r_q;
                en_out_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; rst_n is an active-high synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            r_q      <= {W{1'b0}};
            mn_q     <= {(W+2){1'b0}};
            new_a_q  <= {W{1'b0}};
            en_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            mn_q     <= mn_d;
            new_a_q  <= new_a_d;
            en_out_q <= en_out_d;
        end
    end

    assign new_a  = new_a_q;
    assign en_out = en_out_q;

endmodule

// File: tb/tb_phase_a_core.sv
// Randomized self-checking bench for phase_a_core; expected results come
// from a direct (a << SHIFT) % m computation on wide vectors.
module tb_phase_a_core;

    localparam int W     = 3072;
    localparam int SHIFT = 64;
    localparam int MPW   = 110;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   a;
    logic [W-1:0]   m;
    logic [W+1:0]   m_n;
    logic [MPW-1:0] m_prime;
    logic           en;
    logic [W-1:0]   new_a;
    logic           en_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    phase_a_core #(.SHIFT(SHIFT), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .m       (m),
        .m_n     (m_n),
        .m_prime (m_prime),
        .en      (en),
        .new_a   (new_a),
        .en_out  (en_out)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got(low128)=%h expected(low128)=%h", tag, obs[127:0], exp_v[127:0]);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [W-1:0] av, input logic [W-1:0] mv);
        logic [W+SHIFT-1:0] wide;
        wide = {{SHIFT{1'b0}}, av} << SHIFT;
        wide = wide % {{SHIFT{1'b0}}, mv};
        return wide[W-1:0];
    endfunction

    function automatic logic [W+1:0] neg_mod(input logic [W-1:0] mv);
        return {(W+2){1'b0}} - {2'b00, mv};
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [W-1:0] rand_modulus();
        logic [W-1:0] v;
        v = rand_wide();
        v[W-1] = 1'b1;
        v[0]   = 1'b1;
        return v;
    endfunction

    task automatic start_job(input logic [W-1:0] av, input logic [W-1:0] mv);
        @(negedge clk);
        a       = av;
        m       = mv;
        m_n     = neg_mod(mv);
        m_prime = MPW'({$urandom(), $urandom(), $urandom(), $urandom()});
        en      = 1'b1;
        @(negedge clk);
        en      = 1'b0;
    endtask

    task automatic wait_done(output int lat, input bit scramble);
        lat = -1;
        for (int k = 1; k <= SHIFT + 20; k++) begin
            @(posedge clk);
            #1;
            if (en_out) begin
                lat = k;
                break;
            end
            if (scramble) begin
                a   = rand_wide();
                m   = rand_wide();
                m_n = {rand_wide(), 2'b11};
            end
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (en_out) cnt++;
        end
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] av, input logic [W-1:0] mv,
                             input bit scramble);
        int           lat;
        logic [W-1:0] exp_v;
        exp_v = ref_result(av, mv);
        start_job(av, mv);
        wait_done(lat, scramble);
        check({tag, "_lat"}, W'(lat), W'(SHIFT + 1));
        check({tag, "_res"}, new_a, exp_v);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, W'(en_out), W'(0));
        check({tag, "_hold"}, new_a, exp_v);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] av;
        logic [W-1:0] mv;
        logic [W-1:0] exp_v;
        int           cnt;
        int           lat;

        rst_n   = 1'b1;
        en      = 1'b0;
        a       = {W{1'b0}};
        m       = W'(3);
        m_n     = neg_mod(W'(3));
        m_prime = {MPW{1'b0}};
        repeat (3) @(posedge clk);
        #1;
        check("reset_new_a", new_a, W'(0));
        check("reset_en_out", W'(en_out), W'(0));
        @(negedge clk);
        rst_n = 1'b0;

        run_check("dir_1_3", W'(1), W'(3), 1'b0);
        run_check("dir_5_7", W'(5), W'(7), 1'b0);
        count_pulses(8, cnt);
        check("idle_no_pulse", W'(cnt), W'(0));
        check("idle_hold", new_a, W'(3));
        run_check("dir_a0", {W{1'b0}}, rand_modulus(), 1'b0);

        mv = rand_modulus();
        run_check("a_max", mv - W'(1), mv, 1'b0);

        for (int i = 0; i < 6; i++) begin
            mv = rand_modulus();
            av = rand_wide() % mv;
            run_check("rnd_wide", av, mv, (i % 2) == 1);
        end
        for (int i = 0; i < 4; i++) begin
            mv = W'($urandom_range(1, 5000) * 2 + 1);
            av = W'($urandom()) % mv;
            run_check("rnd_small", av, mv, 1'b1);
        end

        // Reset in the middle of a job: no pulse, result cleared.
        mv = rand_modulus();
        av = rand_wide() % mv;
        start_job(av, mv);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        count_pulses(SHIFT + 10, cnt);
        check("abort_no_pulse", W'(cnt), W'(0));
        check("abort_new_a", new_a, W'(0));
        mv = rand_modulus();
        run_check("after_abort", rand_wide() % mv, mv, 1'b0);

        // Second strobe while running is ignored.
        mv = rand_modulus();
        av = rand_wide() % mv;
        exp_v = ref_result(av, mv);
        start_job(av, mv);
        repeat (5) @(posedge clk);
        @(negedge clk);
        a   = W'(5);
        m   = W'(7);
        m_n = neg_mod(W'(7));
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        wait_done(lat, 1'b0);
        check("run_en_lat", W'(lat), W'(SHIFT - 5));
        check("run_en_res", new_a, exp_v);
        count_pulses(SHIFT + 10, cnt);
        check("run_en_single", W'(cnt), W'(0));

        // Strobe coinciding with DONE is ignored.
        mv = rand_modulus();
        av = rand_wide() % mv;
        exp_v = ref_result(av, mv);
        start_job(av, mv);
        repeat (SHIFT) @(posedge clk);
        @(negedge clk);
        a   = W'(1);
        m   = W'(3);
        m_n = neg_mod(W'(3));
        en  = 1'b1;
        @(posedge clk);
        #1;
        check("done_en_pulse", W'(en_out), W'(1));
        check("done_en_res", new_a, exp_v);
        @(negedge clk);
        en = 1'b0;
        count_pulses(SHIFT + 10, cnt);
        check("done_en_ignored", W'(cnt), W'(0));
        check("done_en_hold", new_a, exp_v);
        run_check("after_done_en", W'(5), W'(7), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
